// File: rtl/wb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM states,
// Wishbone cycle-type / burst-type encodings and the watchdog counter width.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_TOERR = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Stall watchdog counter width (covers TIMEOUT_CYC up to 65535).
  localparam int TO_CW = 16;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: first requester found searching
// upward from (last+1) mod NCH with wrap. Returns one-hot pick, its index
// and a valid flag (any request present).
module wb_rr_pick #(
  parameter int NCH = 2,
  parameter int LW  = 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [LW-1:0]  last_i,
  output logic [NCH-1:0] pick_o,
  output logic [LW-1:0]  idx_o,
  output logic           valid_o
);

  int   cand;
  logic found;

  // Rotating priority scan starting just after the last granted channel.
  always_comb begin
    pick_o = '0;
    idx_o  = last_i;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (int'(last_i) + k) % NCH;
      if (!found && req_i[cand]) begin
        pick_o[cand] = 1'b1;
        idx_o        = LW'(cand);
        found        = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone arbiter: NCH masters share one slave. Grant is held
// for the whole master cycle (any number of beats / burst CTI values).
// Optional stall watchdog compiled in with `define WB_ARB_RR_TIMEOUT_EN:
// after TIMEOUT_CYC unacknowledged strobe cycles the granted master gets a
// one-cycle m_err and the slave cycle is dropped until the master releases.
module wb_arb_rr
  import wb_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int AW          = 30,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        m_cyc,
  input  logic [NCH-1:0]        m_stb,
  input  logic [NCH-1:0]        m_we,
  input  logic [NCH*AW-1:0]     m_adr,
  input  logic [NCH*DW-1:0]     m_dat_mosi,
  input  logic [NCH*(DW/8)-1:0] m_sel,
  input  logic [NCH*2-1:0]      m_bte,
  input  logic [NCH*3-1:0]      m_cti,
  output logic [NCH-1:0]        m_ack,
  output logic [NCH-1:0]        m_err,
  output logic [DW-1:0]         m_dat_miso,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [AW-1:0]         s_adr,
  output logic [DW-1:0]         s_dat_mosi,
  output logic [DW/8-1:0]       s_sel,
  output logic [1:0]            s_bte,
  output logic [2:0]            s_cti,
  input  logic                  s_ack,
  input  logic                  s_err,
  input  logic [DW-1:0]         s_dat_miso,
  output logic [NCH-1:0]        gnt
);

  localparam int SW = DW / 8;
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 1 || NCH > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("wb_arb_rr: NCH or TIMEOUT_CYC out of range");
  end

  state_e         state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [LW-1:0]  last_q, last_d;   // doubles as the granted index while BUSY

  logic [NCH-1:0]         pick;
  logic [LW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   busy;
  logic                   to_hit;

  // Per-channel views of the flat master buses.
  logic [NCH-1:0][AW-1:0] adr_v;
  logic [NCH-1:0][DW-1:0] dat_v;
  logic [NCH-1:0][SW-1:0] sel_v;
  logic [NCH-1:0][1:0]    bte_v;
  logic [NCH-1:0][2:0]    cti_v;

  assign adr_v      = m_adr;
  assign dat_v      = m_dat_mosi;
  assign sel_v      = m_sel;
  assign bte_v      = m_bte;
  assign cti_v      = m_cti;
  assign busy       = (state_q == ST_BUSY);
  assign gnt        = gnt_q;
  assign m_dat_miso = s_dat_miso;

  wb_rr_pick #(.NCH(NCH), .LW(LW)) u_pick (
    .req_i   (m_cyc),
    .last_i  (last_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

`ifdef WB_ARB_RR_TIMEOUT_EN
  logic [TO_CW-1:0] cnt_q, cnt_d;

  // Count unacknowledged strobe cycles; any ack/err or leaving BUSY clears.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy || s_ack || s_err) cnt_d = '0;
    else if (s_stb)              cnt_d = cnt_q + 1'b1;
  end

  assign to_hit = busy && s_stb && !s_ack && !s_err && (cnt_d == TO_CW'(TIMEOUT_CYC));

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // FSM next state: grant in IDLE, hold for the master cycle, optional
  // error/drain path after a watchdog expiry.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          gnt_d   = pick;
          last_d  = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!m_cyc[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (to_hit) begin
          state_d = ST_TOERR;
        end
      end
      ST_TOERR: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!m_cyc[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Slave bus mux and response routing; everything quiet outside BUSY
  // except the single-cycle error pulse in TOERR.
  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_dat_mosi = '0;
    s_sel      = '0;
    s_bte      = '0;
    s_cti      = '0;
    m_ack      = '0;
    m_err      = '0;
    if (busy) begin
      s_cyc          = m_cyc[last_q];
      s_stb          = m_stb[last_q];
      s_we           = m_we[last_q];
      s_adr          = adr_v[last_q];
      s_dat_mosi     = dat_v[last_q];
      s_sel          = sel_v[last_q];
      s_bte          = bte_v[last_q];
      s_cti          = cti_v[last_q];
      m_ack[last_q]  = s_ack && !s_err;   // err wins over a simultaneous ack
      m_err[last_q]  = s_err;
    end else if (state_q == ST_TOERR) begin
      m_err[last_q]  = 1'b1;
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NCH - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule
